// File: rtl/bounce_pkg.sv
// Shared types and constants for the bouncy-switch emulator: FSM states,
// LFSR geometry and the gap arithmetic used to space the bounce toggles.
package bounce_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    SETTLE = 2'd2
  } state_e;

  localparam int              LFSR_W    = 16;
  localparam logic [15:0]     LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0]     LFSR_TAPS = 16'hB400;
  localparam int              GAP_W     = 17;

  // 17-bit sum so MIN_GAP plus the largest masked addend never wraps.
  function automatic logic [GAP_W-1:0] gap_value(input logic [15:0] min_gap,
                                                 input logic [15:0] mask,
                                                 input logic [15:0] rnd);
    return {1'b0, min_gap} + {1'b0, rnd & mask};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR that advances every cycle; supplies the random
// addend for bounce gaps.
module lfsr16
  import bounce_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q
);

  logic [LFSR_W-1:0] lfsr_q;
  logic              fb_d;

  assign fb_d = ^(lfsr_q & LFSR_TAPS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[LFSR_W-2:0], fb_d};
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/bounce_gen.sv
// Emulates a bouncy mechanical switch: each requested level change becomes an
// odd burst of spaced toggles followed by a stable hold. Build option:
// BOUNCE_GEN_LFSR_EN adds an LFSR-randomised addend to every toggle gap.
module bounce_gen
  import bounce_pkg::*;
#(
  parameter int          BOUNCE_CNT = 3,
  parameter int          MIN_GAP    = 1000,
  parameter logic [15:0] GAP_MASK   = 16'h0FFF,
  parameter int          SETTLE_CYC = 5000
) (
  input  logic CLK_100M,
  input  logic RST_N,
  input  logic cmd_level,
  output logic sw_out,
  output logic busy,
  output logic done_tick
);

  localparam int          NUM_TOG   = 2 * BOUNCE_CNT + 1;
  localparam int          TOG_W     = $clog2(NUM_TOG + 1);
  localparam int          SET_W     = $clog2(SETTLE_CYC + 1);
  localparam logic [15:0] MIN_GAP_V = 16'(MIN_GAP);

  state_e             state_q;
  logic               target_q;
  logic               sw_q;
  logic               busy_q;
  logic               done_q;
  logic [TOG_W-1:0]   toggles_q;
  logic [GAP_W-1:0]   gap_q;
  logic [SET_W-1:0]   settle_q;
  logic [GAP_W-1:0]   gap_d;

`ifdef BOUNCE_GEN_LFSR_EN
  logic [15:0] lfsr_q;

  lfsr16 u_lfsr (
    .clk   (CLK_100M),
    .rst_n (RST_N),
    .q     (lfsr_q)
  );

  assign gap_d = gap_value(MIN_GAP_V, GAP_MASK, lfsr_q);
`else
  assign gap_d = gap_value(MIN_GAP_V, GAP_MASK, 16'h0000);
`endif

  always_ff @(posedge CLK_100M or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      target_q  <= 1'b0;
      sw_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      toggles_q <= '0;
      gap_q     <= '0;
      settle_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_level != sw_q) begin
            target_q  <= cmd_level;
            toggles_q <= TOG_W'(NUM_TOG);
            gap_q     <= gap_d;
            busy_q    <= 1'b1;
            state_q   <= BOUNCE;
          end
        end
        BOUNCE: begin
          if (gap_q == GAP_W'(1)) begin
            // The last toggle lands on the target by construction (odd count).
            sw_q      <= (toggles_q == TOG_W'(1)) ? target_q : ~sw_q;
            toggles_q <= toggles_q - TOG_W'(1);
            gap_q     <= gap_d;
            if (toggles_q == TOG_W'(1)) begin
              settle_q <= SET_W'(SETTLE_CYC);
              state_q  <= SETTLE;
            end
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end
        SETTLE: begin
          if (settle_q == SET_W'(1)) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            settle_q <= settle_q - SET_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sw_out    = sw_q;
  assign busy      = busy_q;
  assign done_tick = done_q;

endmodule

// File: tb/tb_bounce_gen.sv
// Bench for bounce_gen: two instances (bouncing and single-toggle) compared every
// cycle against a timestamp-based model, plus directed and random scenarios.
module tb_bounce_gen;

  localparam int A_MIN = 4, A_SET = 8, A_TOG = 5, A_MASK = 7;
  localparam int B_MIN = 3, B_SET = 6, B_TOG = 1, B_MASK = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_level = 1'b0;
  logic sw_a, busy_a, done_a;
  logic sw_b, busy_b, done_b;

  always #5 clk = ~clk;

  bounce_gen #(.BOUNCE_CNT(2), .MIN_GAP(A_MIN), .GAP_MASK(16'h0007), .SETTLE_CYC(A_SET)) u_dut_a (
    .CLK_100M (clk), .RST_N (rst_n), .cmd_level (cmd_level),
    .sw_out (sw_a), .busy (busy_a), .done_tick (done_a)
  );

  bounce_gen #(.BOUNCE_CNT(0), .MIN_GAP(B_MIN), .GAP_MASK(16'h0003), .SETTLE_CYC(B_SET)) u_dut_b (
    .CLK_100M (clk), .RST_N (rst_n), .cmd_level (cmd_level),
    .sw_out (sw_b), .busy (busy_b), .done_tick (done_b)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: absolute edge timestamps of the next scheduled event per instance.
  int          ec;
  logic [15:0] m_lfsr;
  logic        m_sw[2], m_busy[2], m_done[2];
  int          m_left[2], m_next[2];

  // Observation bookkeeping.
  int   tog[2], last[2];
  logic prev_sw[2], prev_busy[2];
  bit   gap_seen[32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int gap_of(input int i, input logic [15:0] rnd);
`ifdef BOUNCE_GEN_LFSR_EN
    return (i == 0) ? A_MIN + int'(rnd & 16'(A_MASK)) : B_MIN + int'(rnd & 16'(B_MASK));
`else
    return (i == 0) ? A_MIN + 0 * int'(rnd) : B_MIN;
`endif
  endfunction

  task automatic model_reset();
    ec = 0;
    m_lfsr = 16'hACE1;
    for (int i = 0; i < 2; i++) begin
      m_sw[i] = 1'b0; m_busy[i] = 1'b0; m_done[i] = 1'b0; m_left[i] = 0; m_next[i] = 0;
    end
  endtask

  task automatic model_edge();
    ec++;
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 1'b0;
      if (!m_busy[i]) begin
        if (cmd_level != m_sw[i]) begin
          m_busy[i] = 1'b1;
          m_left[i] = (i == 0) ? A_TOG : B_TOG;
          m_next[i] = ec + gap_of(i, m_lfsr);
        end
      end else if (m_left[i] > 0) begin
        if (ec == m_next[i]) begin
          m_sw[i] = ~m_sw[i];
          m_left[i]--;
          m_next[i] = (m_left[i] == 0) ? ec + ((i == 0) ? A_SET : B_SET) : ec + gap_of(i, m_lfsr);
        end
      end else if (ec == m_next[i]) begin
        m_busy[i] = 1'b0;
        m_done[i] = 1'b1;
      end
    end
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  endtask

  task automatic track(input int i, input logic sw, input logic bz, input logic dn);
    int g;
    if (!rst_n) begin
      prev_sw[i] = sw; prev_busy[i] = bz;
      return;
    end
    if (bz && !prev_busy[i]) last[i] = cyc;
    if (sw != prev_sw[i]) begin
      tog[i]++;
      g = cyc - last[i];
`ifdef BOUNCE_GEN_LFSR_EN
      chk((i == 0) ? "gap_range_a" : "gap_range_b",
          32'((g >= ((i == 0) ? A_MIN : B_MIN)) && (g <= ((i == 0) ? A_MIN + A_MASK : B_MIN + B_MASK))), 32'd1);
      if (i == 0 && g < 32) gap_seen[g] = 1'b1;
`else
      chk((i == 0) ? "gap_a" : "gap_b", 32'(g), 32'((i == 0) ? A_MIN : B_MIN));
`endif
      last[i] = cyc;
    end
    if (dn) chk((i == 0) ? "settle_a" : "settle_b", 32'(cyc - last[i]), 32'((i == 0) ? A_SET : B_SET));
    prev_sw[i] = sw; prev_busy[i] = bz;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    cyc++;
    chk("sw_a", 32'(sw_a), 32'(m_sw[0]));
    chk("busy_a", 32'(busy_a), 32'(m_busy[0]));
    chk("done_a", 32'(done_a), 32'(m_done[0]));
    chk("sw_b", 32'(sw_b), 32'(m_sw[1]));
    chk("busy_b", 32'(busy_b), 32'(m_busy[1]));
    chk("done_b", 32'(done_b), 32'(m_done[1]));
    track(0, sw_a, busy_a, done_a);
    track(1, sw_b, busy_b, done_b);
  endtask

  task automatic wait_done(input int i, input int budget);
    int k = 0;
    do begin
      step();
      k++;
    end while (!((i == 0) ? done_a : done_b) && k < budget);
    chk((i == 0) ? "done_a_timeout" : "done_b_timeout", 32'((i == 0) ? done_a : done_b), 32'd1);
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 2; i++) begin
      tog[i] = 0; last[i] = 0; prev_sw[i] = 1'b0; prev_busy[i] = 1'b0;
    end
    repeat (3) step();
    chk("rst_sw_a", 32'(sw_a), 32'd0);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_done_a", 32'(done_a), 32'd0);
    rst_n = 1'b1;
    repeat (2) step();

    // Rising transition: five toggles ending high.
    cmd_level = 1'b1; tog[0] = 0;
    wait_done(0, 200);
    chk("rise_toggles_a", 32'(tog[0]), 32'd5);
    chk("rise_final_a", 32'(sw_a), 32'd1);

    // Mirrored falling transition right after done_tick.
    cmd_level = 1'b0; tog[0] = 0;
    wait_done(0, 200);
    chk("fall_toggles_a", 32'(tog[0]), 32'd5);
    chk("fall_final_a", 32'(sw_a), 32'd0);

    // Command reverts mid-bounce: sequence still completes, then a new one returns to 0.
    cmd_level = 1'b1; tog[0] = 0;
    repeat (6) step();
    chk("mid_busy_a", 32'(busy_a), 32'd1);
    cmd_level = 1'b0;
    wait_done(0, 200);
    chk("revert_final_a", 32'(sw_a), 32'd1);
    chk("revert_toggles_a", 32'(tog[0]), 32'd5);
    tog[0] = 0;
    wait_done(0, 200);
    chk("return_final_a", 32'(sw_a), 32'd0);
    chk("return_toggles_a", 32'(tog[0]), 32'd5);

    // Zero-bounce instance: single clean toggle.
    cmd_level = 1'b1; tog[1] = 0;
    wait_done(1, 100);
    chk("single_toggle_b", 32'(tog[1]), 32'd1);
    chk("single_final_b", 32'(sw_b), 32'd1);
    wait_done(0, 200);
    cmd_level = 1'b0;
    wait_done(0, 200);

    // Reset after the third toggle of a rising sequence aborts immediately.
    cmd_level = 1'b1; tog[0] = 0;
    for (int k = 0; k < 200 && tog[0] < 3; k++) step();
    chk("third_toggle_seen", 32'(tog[0]), 32'd3);
    chk("pre_abort_sw_a", 32'(sw_a), 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("abort_sw_a", 32'(sw_a), 32'd0);
    chk("abort_busy_a", 32'(busy_a), 32'd0);
    chk("abort_done_a", 32'(done_a), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("restart_busy_a", 32'(busy_a), 32'd1);
    wait_done(0, 200);
    chk("restart_final_a", 32'(sw_a), 32'd1);

    // Random commands, sub-cycle glitches and occasional resets.
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 60)) step();
      case ($urandom_range(0, 3))
        0, 1: cmd_level = ~cmd_level;
        2: begin
          cmd_level = ~cmd_level;
          #2 cmd_level = ~cmd_level;
        end
        default: begin
          if ($urandom_range(0, 3) == 0) begin
            rst_n = 1'b0;
            model_reset();
            step();
            rst_n = 1'b1;
          end
        end
      endcase
    end
    repeat (100) step();

`ifdef BOUNCE_GEN_LFSR_EN
    begin
      int distinct = 0;
      for (int g = 0; g < 32; g++) if (gap_seen[g]) distinct++;
      chk("distinct_gaps", 32'(distinct >= 2), 32'd1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bounce_gen.md
BOUNCE_GEN -- requirements
Module: bounce_gen

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter BOUNCE_CNT, default 3, SHALL set the number of extra toggle pairs per transition, giving 2*BOUNCE_CNT+1 toggles in total.
REQ-003 Parameter MIN_GAP, default 1000, SHALL set the minimum number of cycles between toggles (legal range 1..65535).
REQ-004 Parameter GAP_MASK, default 16'h0FFF, SHALL mask the random addend applied to MIN_GAP.
REQ-005 Parameter SETTLE_CYC, default 5000, SHALL set the stable hold time after the final toggle (legal range >=1).
REQ-006 CLK_100M  input  1  system clock.
REQ-007 RST_N  input  1  asynchronous active-low reset.
REQ-008 cmd_level  input  1  clean requested switch level, synchronous to CLK_100M.
REQ-009 sw_out  output  1  emulated bouncy mechanical switch level, registered.
REQ-010 busy  output  1  high in BOUNCE and SETTLE.
REQ-011 done_tick  output  1  one-cycle pulse when a transition has fully settled.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, BOUNCE, SETTLE.
REQ-013 In IDLE, when cmd_level != sw_out, the FSM SHALL latch target = cmd_level, load toggles_left = 2*BOUNCE_CNT+1, load gap_cnt = gap value, and move to BOUNCE.
- The comparison is made on the next clock edge.
REQ-014 Gap value SHALL be MIN_GAP + (lfsr & GAP_MASK), computed in 17 bits with no wrap.
REQ-015 In BOUNCE, gap_cnt SHALL decrement by 1 each cycle.
- When gap_cnt == 1, the next edge SHALL toggle sw_out, decrement toggles_left and reload gap_cnt with a fresh gap value.
REQ-016 The first toggle SHALL occur exactly gap-value cycles after the BOUNCE entry edge.
REQ-017 When the toggle that brings toggles_left to 0 occurs, sw_out SHALL equal target, and the FSM SHALL enter SETTLE with a counter of SETTLE_CYC.
REQ-018 In SETTLE, sw_out SHALL hold.
- After SETTLE_CYC cycles, done_tick SHALL pulse for one cycle and the FSM SHALL return to IDLE.
REQ-019 Changes of cmd_level during BOUNCE or SETTLE SHALL be ignored.
- A mismatch still present in IDLE SHALL start a new sequence on the cycle after done_tick.
REQ-020 The LFSR SHALL be a 16-bit Fibonacci LFSR, taps 16,14,13,11, advancing once per cycle in every state.
REQ-021 When BOUNCE_CNT=0, a transition SHALL be a single clean toggle followed by SETTLE.
REQ-022 A cmd_level pulse shorter than one cycle-edge sample SHALL have no effect.

Reset
REQ-023 While RST_N is low, the block SHALL hold:
- state = IDLE
- sw_out = 0, busy = 0, done_tick = 0
- all counters = 0
- lfsr = 16'hACE1
REQ-024 Reset asserted mid-BOUNCE or mid-SETTLE SHALL abort immediately with no done_tick.
REQ-025 After reset release, sw_out = 0, so cmd_level = 1 SHALL start a sequence on the first edge.

Configuration
REQ-026 With BOUNCE_GEN_LFSR_EN defined, gap values SHALL use the LFSR per REQ-014.
REQ-027 With BOUNCE_GEN_LFSR_EN undefined:
- every gap value SHALL equal MIN_GAP;
- the LFSR and its sub-module SHALL not be instantiated.

Structure
REQ-028 Package bounce_pkg SHALL hold:
- the state enum (IDLE/BOUNCE/SETTLE);
- LFSR width 16, seed 16'hACE1 and tap mask;
- gap counter width 17.
REQ-029 The LFSR SHALL be the sub-module lfsr16, with ports clk, rst_n and q[15:0].

Verification
REQ-030 Macro off, BOUNCE_CNT=2, MIN_GAP=4, SETTLE_CYC=8: cmd_level 0->1 -> sw_out toggles 5 times, 4 cycles apart, ends at 1; done_tick fires 8 cycles after the last toggle; busy is high throughout.
REQ-031 Same configuration, cmd_level 1->0 after done_tick -> mirrored sequence, ending at 0.
REQ-032 cmd_level toggled back to 0 during BOUNCE -> sequence completes at 1; after done_tick, a new 5-toggle sequence returns sw_out to 0.
REQ-033 RST_N pulsed low after the 3rd toggle -> sw_out = 0, busy = 0 immediately, no done_tick; with cmd_level = 1, a new sequence starts after release.
REQ-034 Macro on, MIN_GAP=4, GAP_MASK=16'h7 -> every observed gap lies in 4..11, and at least two distinct gaps appear in 20 toggles.
REQ-035 BOUNCE_CNT=0 -> exactly one toggle, then done_tick after SETTLE_CYC.
